// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - shared types, widths and codes for the ATS21 command master
package ats21_pkg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 24;
    localparam int CMD_W  = 2 * CTRL_W;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SET_CLK   = 3'b001,
        OP_EN_CLK    = 3'b010,
        OP_SET_MODE  = 3'b011,
        OP_SET_ALARM = 3'b101,
        OP_SET_TIMER = 3'b110,
        OP_EN_ALARM  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_WAIT_RSP,
        ST_RESP
    } state_e;

    localparam logic [1:0] STAT_LOCAL_REJECT = 2'b11;

    // 3'b100 is the one opcode with no ATS21 meaning
    function automatic logic is_undef_op(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1 -: 3] == 3'b100;
    endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// rtl/ats21_cmd_fifo.sv - synchronous command FIFO, power-of-2 depth, async active-low reset
module ats21_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ats21_cmd_master.sv
// rtl/ats21_cmd_master.sv - ATS21 host-side command initiator; ATS21_OPCHK_EN rejects opcode 3'b100 locally
module ats21_cmd_master
    import ats21_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int TO_W       = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_ready,
    output logic              req,
    output logic [CTRL_W-1:0] ctrlA,
    output logic [CTRL_W-1:0] ctrlB,
    input  logic              ready,
    input  logic [1:0]        stat,
    input  logic [DATA_W-1:0] data,
    output logic              rsp_valid,
    output logic [1:0]        rsp_stat,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [1:0]          rsp_stat_q, rsp_stat_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]    fifo_rdata;

    ats21_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid && !fifo_full),
        .wdata (cmd_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready   = !fifo_full;
    assign ctrlB       = '0;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_stat    = rsp_stat_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        rsp_stat_d    = rsp_stat_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;
        req           = 1'b0;
        ctrlA         = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    state_d  = ST_SEND_HI;
`ifdef ATS21_OPCHK_EN
                    if (is_undef_op(fifo_rdata)) begin
                        state_d       = ST_RESP;
                        rsp_stat_d    = STAT_LOCAL_REJECT;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                    end
`endif
                end
            end
            ST_SEND_HI: begin
                req     = 1'b1;
                ctrlA   = cmd_q[CMD_W-1:CTRL_W];
                state_d = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                req     = 1'b1;
                ctrlA   = cmd_q[CTRL_W-1:0];
                cnt_d   = '0;
                state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                // a response on the terminal cycle still counts as a real answer
                if (ready) begin
                    rsp_stat_d    = stat;
                    rsp_data_d    = data;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_stat_d    = '0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            cnt_q         <= '0;
            rsp_stat_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            rsp_stat_q    <= rsp_stat_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_ats21_cmd_master.sv
// tb/tb_ats21_cmd_master.sv - scoreboard bench for ats21_cmd_master (either ATS21_OPCHK_EN build)
module tb_ats21_cmd_master;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready;
    logic        req;
    logic [15:0] ctrlA, ctrlB;
    logic        ready = 1'b0;
    logic [1:0]  stat = '0;
    logic [23:0] data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_stat;
    logic [23:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [15:0] exp_ctrl_q[$];
    logic [26:0] exp_rsp_q[$];

    ats21_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
        .ready(ready), .stat(stat), .data(data), .rsp_valid(rsp_valid),
        .rsp_stat(rsp_stat), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: every req cycle and every response must match the next expectation
    always @(negedge clk) begin
        if (req === 1'b1) begin
            check("req_expected", 32'(exp_ctrl_q.size() != 0), 1);
            if (exp_ctrl_q.size() != 0) check("ctrlA", ctrlA, exp_ctrl_q.pop_front());
            check("ctrlB", ctrlB, 0);
        end
        if (rsp_valid === 1'b1) begin
            check("rsp_expected", 32'(exp_rsp_q.size() != 0), 1);
            if (exp_rsp_q.size() != 0)
                check("rsp", {rsp_timeout, rsp_stat, rsp_data}, exp_rsp_q.pop_front());
        end
    end

    task automatic push_cmd(input logic [31:0] c, input bit issued, output bit stalled);
        bit accepted = 0;
        stalled = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready === 1'b1) begin
                accepted = 1;
                break;
            end
            stalled = 1;
            @(negedge clk);
        end
        check("push_accepted", 32'(accepted), 1);
        if (issued) begin
            exp_ctrl_q.push_back(c[31:16]);
            exp_ctrl_q.push_back(c[15:0]);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // ATS21 model: raise ready 'delay' cycles after req falls (delay<=0: never)
    task automatic respond(input int delay, input logic [1:0] st, input logic [23:0] dt);
        int n;
        int k;
        int exp_lat;
        logic [26:0] exp_r;
        if (delay <= 0 || delay > TIMEOUT) begin
            exp_r   = {1'b1, 2'b00, 24'h0};
            exp_lat = TIMEOUT + 1;
        end else begin
            exp_r   = {1'b0, st, dt};
            exp_lat = delay + 1;
        end
        exp_rsp_q.push_back(exp_r);
        n = 0;
        do begin @(negedge clk); n++; end while (req !== 1'b1 && n < 400);
        check("req_seen", 32'(req), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (req === 1'b1 && n < 10);
        check("req_two_cycles", n, 2);
        k = 1;
        while (rsp_valid !== 1'b1 && k < 300) begin
            if (k == delay) begin
                ready = 1'b1;
                stat  = st;
                data  = dt;
            end
            @(negedge clk);
            ready = 1'b0;
            stat  = 2'($urandom);
            data  = 24'($urandom);
            k++;
        end
        check("rsp_latency", k, exp_lat);
        @(negedge clk);
        check("rsp_hold", {rsp_timeout, rsp_stat, rsp_data}, exp_r);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit st_flag;
        bit any_stall;

        repeat (2) @(negedge clk);
        check("rst_req", 32'(req), 0);
        check("rst_ctrlA", ctrlA, 0);
        check("rst_ctrlB", ctrlB, 0);
        check("rst_rsp", {rsp_valid, rsp_timeout, rsp_stat, rsp_data}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        reset = 1'b1;

        // stray ready in IDLE must not create a response
        @(negedge clk); ready = 1'b1; stat = 2'b10; data = 24'hBAD;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        check("idle_ready_no_capture", {rsp_timeout, rsp_stat, rsp_data}, 0);

        // first command, with push-to-req timing
        fork
            respond(3, 2'b01, 24'h00_1234);
            begin
                push_cmd(32'h2A40_0000, 1, st_flag);
                @(negedge clk); check("req_edge_n1", 32'(req), 0);
                @(negedge clk); check("req_edge_n2", 32'(req), 1);
                @(negedge clk); check("req_edge_n3", 32'(req), 1);
                @(negedge clk); check("req_edge_n4", 32'(req), 0);
            end
        join

        fork respond(1, 2'b10, 24'hAB_CDEF); push_cmd(32'h0000_0000, 1, st_flag); join
        fork respond(0, 2'b01, 24'h11_1111); push_cmd(32'h4000_0001, 1, st_flag); join
        fork respond(TIMEOUT, 2'b01, 24'h55_AA55); push_cmd(32'h6123_4567, 1, st_flag); join

        // six back-to-back commands into a depth-4 FIFO
        any_stall = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                push_cmd(32'hA000_0000 | (i * 32'h0001_0101), 1, st_flag);
                any_stall |= st_flag;
            end
            for (int i = 0; i < 6; i++) respond(2, 2'(i), 24'h10_0000 + 24'(i));
        join
        check("fifo_full_stall", 32'(any_stall), 1);
        check("ctrl_q_drained", exp_ctrl_q.size(), 0);
        check("rsp_q_drained", exp_rsp_q.size(), 0);

        // reset during SEND_LO with two more commands buffered
        push_cmd(32'hC0DE_0001, 1, st_flag);
        push_cmd(32'hC0DE_0002, 1, st_flag);
        push_cmd(32'hC0DE_0003, 1, st_flag);
        check("pre_reset_req", 32'(req), 1);
        #1 reset = 1'b0;
        #1;
        check("abort_req", 32'(req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        exp_ctrl_q.delete();
        @(negedge clk) reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_abort_busy", 32'(busy), 0);

`ifdef ATS21_OPCHK_EN
        exp_rsp_q.push_back({1'b0, 2'b11, 24'h0});
        push_cmd(32'h8000_0000, 0, st_flag);
        repeat (8) @(negedge clk);
        check("reject_rsp_seen", exp_rsp_q.size(), 0);
`else
        fork respond(2, 2'b01, 24'h00_0800); push_cmd(32'h8000_0000, 1, st_flag); join
        check("undef_op_issued", exp_ctrl_q.size(), 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
